key_word_entry: RTL
===================

KEY_WORD_ENTRY -- requirements
Module: key_word_entry

Interface
REQ-001 Parameter DIGITS, default 4: number of 4-bit hex digits in one entered word; word width W = 4*DIGITS.
REQ-002 Parameter DEPTH, default 4, power of two: number of entries in the output word FIFO.
REQ-003 Port Clk  input  1: single clock; all state changes on the rising edge.
REQ-004 Port Rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port KeyInc  input  1: debounced one-cycle pulse that increments the current digit.
REQ-006 Port KeyShift  input  1: debounced one-cycle pulse that commits the current digit into the word.
REQ-007 Port KeyEnter  input  1: debounced one-cycle pulse that pushes the assembled word to the FIFO.
REQ-008 Port KeyClear  input  1: debounced one-cycle pulse that aborts entry.
REQ-009 Port Digit  output  4: current digit value, for display.
REQ-010 Port Entry  output  W: assembled word so far, for display.
REQ-011 Port State  output  2: entry state encoding (EMPTY=0, EDIT=1, FULL=2).
REQ-012 Port WordOut  output  W: FIFO head word.
REQ-013 Port WordValid  output  1: FIFO non-empty.
REQ-014 Port WordReady  input  1: consumer accepts the head word when WordValid && WordReady.
REQ-015 Port Overflow  output  1: sticky flag set when an Enter is dropped.

Function
REQ-016 Key inputs SHALL be sampled on Clk and acted on in the same edge; there is no input synchronisation inside this block.
REQ-017 Same-cycle key priority SHALL be Clear > Enter > Shift > Inc; only the highest-priority asserted key takes effect.
REQ-018 Inc SHALL set Digit <= Digit+1 modulo 16 (0xF wraps to 0x0) in every state.
REQ-019 Shift in EMPTY or EDIT SHALL set Entry <= {Entry[W-5:0], Digit} and Digit <= 0, and SHALL increment the digit count.
REQ-020 When the digit count reaches DIGITS, State SHALL move to FULL; otherwise Shift moves EMPTY to EDIT.
REQ-021 Shift in FULL SHALL be ignored, leaving Entry, Digit and the count unchanged.
REQ-022 Enter in EMPTY SHALL be ignored.
REQ-023 Enter in EDIT or FULL with the FIFO not full SHALL push Entry into the FIFO, then clear Entry, Digit and the count, and return State to EMPTY.
REQ-024 Enter with the FIFO full and no pop in the same cycle SHALL drop the word, set Overflow, and leave the entry state unchanged.
REQ-025 Enter with the FIFO full and a pop in the same cycle SHALL be accepted, with occupancy unchanged.
REQ-026 Clear SHALL zero Entry, Digit and the count, set State to EMPTY, and clear Overflow; it SHALL NOT alter FIFO contents.
REQ-027 A pop SHALL occur exactly when WordValid && WordReady; WordOut SHALL then present the next entry on the following cycle.
REQ-028 A pushed word SHALL appear on WordOut with WordValid=1 one cycle after the Enter edge (latency 1) when the FIFO was empty.
REQ-029 FIFO order SHALL be strictly first-in first-out; read and write pointers wrap modulo DEPTH; occupancy ranges 0..DEPTH.
REQ-030 WordOut SHALL hold a stable value while WordValid=1 and WordReady=0.

Reset
REQ-031 Rst_n low SHALL immediately force Digit=0, Entry=0, State=EMPTY, count=0, FIFO empty (WordValid=0), WordOut=0 and Overflow=0, regardless of Clk.
REQ-032 Key pulses arriving while Rst_n is low, or on the first edge after release, SHALL have no effect, and reset asserted mid-entry SHALL discard the partial word.

Verification
REQ-033 Scenario: 3 Inc, Shift, 0 Inc, Shift, 1 Inc, Shift, 15 Inc, Shift, Enter, WordReady=1 -> State FULL after the 4th Shift, then WordOut=0x301F with WordValid high for 1 cycle, then State EMPTY.
REQ-034 Scenario: 17 Inc pulses -> Digit=0x1 (wrap), Entry unchanged at 0.
REQ-035 Scenario: WordReady=0, push 5 distinct words with DEPTH=4 -> 5th dropped and Overflow=1; then WordReady=1 -> first 4 words drain in order, then Clear -> Overflow=0.
REQ-036 Scenario: KeyClear and KeyEnter in the same cycle in EDIT -> no push, State EMPTY, Entry=0.
REQ-037 Scenario: FIFO full with WordReady=1 and Enter in the same cycle -> new word accepted, WordValid stays 1, Overflow stays 0.
REQ-038 Scenario: Rst_n pulsed low mid-cycle after 2 Shifts with 2 words queued -> all outputs zero asynchronously, and the next Enter is ignored.

Source files
------------

// File: rtl/key_word_entry.sv
// key_word_entry: hex keypad word assembler feeding a small first-in first-out word queue.
// Keys are one-cycle debounced pulses; a priority encoder picks one action per edge.
module key_word_entry #(
    parameter int DIGITS = 4,
    parameter int DEPTH  = 4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  KeyInc,
    input  logic                  KeyShift,
    input  logic                  KeyEnter,
    input  logic                  KeyClear,
    output logic [3:0]            Digit,
    output logic [4*DIGITS-1:0]   Entry,
    output logic [1:0]            State,
    output logic [4*DIGITS-1:0]   WordOut,
    output logic                  WordValid,
    input  logic                  WordReady,
    output logic                  Overflow
);
    localparam int W  = 4 * DIGITS;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {EMPTY = 2'd0, EDIT = 2'd1, FULL = 2'd2} state_t;

    state_t         state, state_nx;
    logic [3:0]     digit_nx;
    logic [W-1:0]   entry_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           ovf_nx;
    logic           armed;
    logic [W-1:0]   mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [AW:0]    occ;
    logic           inc, shift, enter, clear;
    logic           fifo_full, pop, push;

    // armed stays low for the first edge after reset release so stray pulses are ignored
    assign clear     = armed & KeyClear;
    assign enter     = armed & KeyEnter & ~KeyClear;
    assign shift     = armed & KeyShift & ~KeyEnter & ~KeyClear;
    assign inc       = armed & KeyInc & ~KeyShift & ~KeyEnter & ~KeyClear;
    assign WordValid = (occ != '0);
    assign fifo_full = (occ == (AW+1)'(DEPTH));
    assign pop       = WordValid & WordReady;
    assign WordOut   = WordValid ? mem[rd_ptr] : '0;
    assign State     = state;

    always_comb begin
        state_nx = state;
        digit_nx = Digit;
        entry_nx = Entry;
        cnt_nx   = cnt;
        ovf_nx   = Overflow;
        push     = 1'b0;
        if (clear) begin
            state_nx = EMPTY;
            digit_nx = '0;
            entry_nx = '0;
            cnt_nx   = '0;
            ovf_nx   = 1'b0;
        end else if (enter && state != EMPTY) begin
            if (!fifo_full || pop) begin
                push     = 1'b1;
                state_nx = EMPTY;
                digit_nx = '0;
                entry_nx = '0;
                cnt_nx   = '0;
            end else begin
                ovf_nx = 1'b1;
            end
        end else if (shift && state != FULL) begin
            entry_nx = (Entry << 4) | W'(Digit);
            digit_nx = '0;
            cnt_nx   = cnt + 1'b1;
            state_nx = (cnt == CW'(DIGITS - 1)) ? FULL : EDIT;
        end else if (inc) begin
            digit_nx = Digit + 4'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= EMPTY;
            Digit    <= '0;
            Entry    <= '0;
            cnt      <= '0;
            Overflow <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nx;
            Digit    <= digit_nx;
            Entry    <= entry_nx;
            cnt      <= cnt_nx;
            Overflow <= ovf_nx;
            armed    <= 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // storage needs no reset: WordOut is masked to zero whenever the queue is empty
    always_ff @(posedge Clk) begin
        if (push)
            mem[wr_ptr] <= Entry;
    end

endmodule
